// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: active-low 7-segment
// codes (bit order {g,f,e,d,c,b,a}) and the all-anodes-off pattern.
package stopwatch_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ANODES_OFF = 4'b1111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low 7-segment decoder. Non-BCD codes
// (10..15) show a dash so a corrupted digit is visible rather than silent.
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Map each BCD value to its segment pattern; anything above 9 is a dash
    always_comb begin
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexes four BCD digits onto one common-anode 7-segment display.
// The digits are snapshotted once per full scan so a counter carry ripple
// can never show a torn value. Each digit slot starts with a short all-off
// guard window to suppress ghosting between anodes.
module seg_display_mux
    import stopwatch_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit0,
    input  logic [3:0] digit1,
    input  logic [3:0] digit2,
    input  logic [3:0] digit3,
    input  logic [3:0] dp_mask,
    input  logic       blank_lz,
    input  logic       enable,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic [1:0] slot
);

    localparam int               CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       slot_reg;
    logic [3:0]       snap_digit_reg [NUM_DIGITS];
    logic [3:0]       snap_dp_reg;

    logic [3:0]       digit_in [NUM_DIGITS];
    logic [3:0]       digit_is_zero;
    logic [3:0]       lz_mask;
    logic             snap_load;

    logic [6:0]       dec_seg;
    logic [6:0]       seg_n_reg, seg_n_next;
    logic             dp_n_reg,  dp_n_next;
    logic [3:0]       an_n_reg,  an_n_next;

    assign digit_in[0] = digit0;
    assign digit_in[1] = digit1;
    assign digit_in[2] = digit2;
    assign digit_in[3] = digit3;

    // Capture happens on the first cycle of slot 0, which is always inside
    // the blank window, so the decoder never drives a half-updated digit.
    assign snap_load = (cnt_reg == '0) && (slot_reg == 2'd0);

    // Prescaler and slot sequencer: slot advances on the prescaler wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            slot_reg <= 2'd0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg  <= '0;
            slot_reg <= slot_reg + 2'd1;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_snap
            // Per-digit snapshot register, reloaded once per full scan
            always_ff @(posedge clk) begin
                if (reset) begin
                    snap_digit_reg[gi] <= 4'd0;
                    snap_dp_reg[gi]    <= 1'b0;
                end else if (snap_load) begin
                    snap_digit_reg[gi] <= digit_in[gi];
                    snap_dp_reg[gi]    <= dp_mask[gi];
                end
            end

            assign digit_is_zero[gi] = (snap_digit_reg[gi] == 4'd0);
        end

        // A digit is a leading zero when it and every more significant
        // digit are zero; the rightmost digit always stays visible.
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
            assign lz_mask[gi] = &digit_is_zero[NUM_DIGITS-1:gi];
        end
    endgenerate

    assign lz_mask[0] = 1'b0;

    seg7_decoder u_decoder (
        .bcd   (snap_digit_reg[slot_reg]),
        .seg_n (dec_seg)
    );

    // Next display state from the current slot, prescaler phase and snapshot
    always_comb begin
        an_n_next  = ANODES_OFF;
        seg_n_next = SEG_BLANK;
        dp_n_next  = 1'b1;
        if (enable && (cnt_reg >= CNT_BLANK)) begin
            an_n_next  = ~(4'b0001 << slot_reg);
            seg_n_next = (blank_lz && lz_mask[slot_reg]) ? SEG_BLANK : dec_seg;
            dp_n_next  = ~snap_dp_reg[slot_reg];
        end
    end

    // Registered display outputs so the pins never glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            an_n_reg  <= ANODES_OFF;
            seg_n_reg <= SEG_BLANK;
            dp_n_reg  <= 1'b1;
        end else begin
            an_n_reg  <= an_n_next;
            seg_n_reg <= seg_n_next;
            dp_n_reg  <= dp_n_next;
        end
    end

    assign an_n  = an_n_reg;
    assign seg_n = seg_n_reg;
    assign dp_n  = dp_n_reg;
    assign slot  = slot_reg;

endmodule

// File: tb/tb_seg_display_mux.sv
// Self-checking bench for seg_display_mux with REFRESH_DIV=4, BLANK_CYCLES=1.
// A time-indexed reference model predicts every output cycle; a vector table
// checks the first full scan per input pattern; directed sequences cover
// snapshot integrity and enable outages; a random phase closes it out.
module tb_seg_display_mux;

    localparam int RD = 4;
    localparam int BC = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] dp_mask;
    logic       blank_lz;
    logic       enable;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic [1:0] slot;

    seg_display_mux #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .digit3   (digit3),
        .dp_mask  (dp_mask),
        .blank_lz (blank_lz),
        .enable   (enable),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .an_n     (an_n),
        .slot     (slot)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state: cycles elapsed since reset plus the captured scan data
    int         k;
    logic [3:0] m_snap [4];
    logic [3:0] m_dp;
    logic [6:0] dec_tab [16];
    logic [1:0] e_slot;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    // Last values seen on each anode while it was lit
    logic [6:0] obs_seg [4];
    logic       obs_dp  [4];
    logic [3:0] obs_seen;

    typedef struct packed {
        logic [15:0] digs;   // {d3,d2,d1,d0}
        logic [3:0]  dp;
        logic        lz;
        logic [27:0] segs;   // expected seg_n {s3,s2,s1,s0}
        logic [3:0]  dpn;    // expected dp_n per slot
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic set_digits(input logic [15:0] v);
        digit0 = v[3:0];
        digit1 = v[7:4];
        digit2 = v[11:8];
        digit3 = v[15:12];
    endtask

    // Predict the outputs for the coming edge, advance the model, clock, compare
    task automatic tick();
        int  c, s;
        bit  nz;
        if (reset) begin
            k = 0;
            for (int j = 0; j < 4; j++) m_snap[j] = 4'd0;
            m_dp  = 4'd0;
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            c = k % RD;
            s = (k / RD) % 4;
            if (!enable || c < BC) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_an = 4'hF ^ (4'h1 << s);
                nz = 1'b0;
                for (int j = s; j < 4; j++) if (m_snap[j] != 4'd0) nz = 1'b1;
                e_seg = (blank_lz && s != 0 && !nz) ? 7'h7F : dec_tab[m_snap[s]];
                e_dp  = ~m_dp[s];
            end
            if (c == 0 && s == 0) begin
                m_snap[0] = digit0;
                m_snap[1] = digit1;
                m_snap[2] = digit2;
                m_snap[3] = digit3;
                m_dp      = dp_mask;
            end
            k++;
        end
        e_slot = 2'((k / RD) % 4);
        @(posedge clk);
        #1;
        check("model", {18'd0, slot, an_n, seg_n, dp_n}, {18'd0, e_slot, e_an, e_seg, e_dp});
        for (int j = 0; j < 4; j++) begin
            if (an_n[j] == 1'b0) begin
                obs_seg[j]  = seg_n;
                obs_dp[j]   = dp_n;
                obs_seen[j] = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
    endtask

    task automatic clear_obs();
        for (int j = 0; j < 4; j++) begin
            obs_seg[j] = 7'h55;
            obs_dp[j]  = 1'bx;
        end
        obs_seen = 4'd0;
    endtask

    // Advance until the model's cycle index reaches target (bounded by construction)
    task automatic tick_to(input int target);
        for (int i = 0; i < 200 && k < target; i++) tick();
    endtask

    initial begin
        dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

        vecs[0] = '{16'h4321, 4'b0000, 1'b0, {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1111};
        vecs[1] = '{16'h8888, 4'b0000, 1'b0, {7'h00, 7'h00, 7'h00, 7'h00}, 4'b1111};
        vecs[2] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
        vecs[3] = '{16'h0050, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0C00, 4'b0100, 1'b1, {7'h7F, 7'h3F, 7'h40, 7'h40}, 4'b1011};
        vecs[5] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[6] = '{16'h1009, 4'b0000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h10}, 4'b1111};
        vecs[7] = '{16'h0000, 4'b1111, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0000};

        k        = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        blank_lz = 1'b0;
        dp_mask  = 4'd0;
        set_digits(16'h4321);
        clear_obs();

        // Reset hold: outputs must stay dark for all three reset cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset_dark", {an_n, seg_n, dp_n}, {4'hF, 7'h7F, 1'b1});
        end
        reset = 1'b0;

        // Table: first full scan after reset for each pattern
        for (int v = 0; v < 8; v++) begin
            set_digits(vecs[v].digs);
            dp_mask  = vecs[v].dp;
            blank_lz = vecs[v].lz;
            enable   = 1'b1;
            do_reset(2);
            clear_obs();
            for (int i = 0; i < 18; i++) tick();
            for (int j = 0; j < 4; j++) begin
                check($sformatf("vec%0d_seg%0d", v, j), {25'd0, obs_seg[j]}, {25'd0, vecs[v].segs[j*7 +: 7]});
                check($sformatf("vec%0d_dp%0d", v, j), {31'd0, obs_dp[j]}, {31'd0, vecs[v].dpn[j]});
            end
            check($sformatf("vec%0d_seen", v), {28'd0, obs_seen}, 32'hF);
        end

        // Snapshot integrity: digit3 changes mid-scan, appears only next scan
        set_digits(16'h4321);
        dp_mask  = 4'd0;
        blank_lz = 1'b0;
        do_reset(2);
        tick_to(6);
        digit3 = 4'd7;
        tick_to(15);
        check("snap_old_an", {28'd0, an_n}, {28'd0, 4'b0111});
        check("snap_old_seg", {25'd0, seg_n}, {25'd0, 7'h19});
        tick_to(31);
        check("snap_new_an", {28'd0, an_n}, {28'd0, 4'b0111});
        check("snap_new_seg", {25'd0, seg_n}, {25'd0, 7'h78});

        // Enable outage mid-scan: dark during, scan resumes in step with the counter
        tick_to(37);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("outage_dark", {28'd0, an_n}, {28'd0, 4'hF});
        end
        enable = 1'b1;
        for (int i = 0; i < 24; i++) tick();

        // Random stimulus against the model, with occasional resets
        for (int i = 0; i < 1500; i++) begin
            set_digits(16'($urandom));
            dp_mask  = 4'($urandom);
            blank_lz = 1'($urandom);
            enable   = ($urandom_range(0, 9) != 0);
            reset    = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) != 0) begin
                // Bias toward zeros so leading-zero blanking gets exercised
                if ($urandom_range(0, 1) != 0) digit3 = 4'd0;
                if ($urandom_range(0, 1) != 0) digit2 = 4'd0;
                if ($urandom_range(0, 1) != 0) digit1 = 4'd0;
            end
            tick();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
